// File: rtl/branch_pred_ctrl_pkg.sv
// Shared datapath types for fetch-stage branch prediction.
//   bpred_t        : 2-bit predictor state (not-taken/taken, hard/soft)
//   bpq_entry_t    : one in-flight prediction {pc, pred, npc}
//   bpred_next()   : predictor state step for a resolved outcome
//   bpred_is_taken(): whether a state predicts taken
package branch_pred_ctrl_pkg;

  typedef enum logic [1:0] {
    BPRED_NH = 2'b00,  // not-taken, hard
    BPRED_NS = 2'b01,  // not-taken, soft
    BPRED_TH = 2'b10,  // taken, hard
    BPRED_TS = 2'b11   // taken, soft
  } bpred_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] npc;
  } bpq_entry_t;

  // Taken walks NH->NS->TH (TS recovers straight to TH); not-taken walks
  // TH->TS->NH (NS falls straight back to NH).
  function automatic bpred_t bpred_next(input bpred_t cur, input logic taken);
    bpred_t nxt;
    case (cur)
      BPRED_NH: nxt = taken ? BPRED_NS : BPRED_NH;
      BPRED_NS: nxt = taken ? BPRED_TH : BPRED_NH;
      BPRED_TH: nxt = taken ? BPRED_TH : BPRED_TS;
      BPRED_TS: nxt = taken ? BPRED_TH : BPRED_NH;
      default:  nxt = BPRED_NH;
    endcase
    return nxt;
  endfunction

  function automatic logic bpred_is_taken(input bpred_t cur);
    return (cur == BPRED_TH) || (cur == BPRED_TS);
  endfunction

endpackage

// File: rtl/branch_pred_ctrl_queue.sv
// In-flight prediction FIFO (power-of-2 depth).
//   CLK, nRST : clock, async active-low reset
//   push/wdata: enqueue when not full
//   pop       : dequeue head when not empty
//   clear     : synchronous empty; overrides push/pop
//   head      : current head entry (valid when ~empty)
//   full, empty, count : occupancy
module branch_pred_ctrl_queue
  import branch_pred_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  bpq_entry_t       wdata,
  output bpq_entry_t       head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  bpq_entry_t       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   cnt_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (cnt_r == (PTR_W+1)'(DEPTH));
  assign empty     = (cnt_r == {(PTR_W+1){1'b0}});
  assign count     = cnt_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {(PTR_W+1){1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {(PTR_W+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + {{PTR_W{1'b0}}, 1'b1};
        2'b01:   cnt_r <= cnt_r - {{PTR_W{1'b0}}, 1'b1};
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Fetch-stage branch prediction controller.
//   CLK, nRST                : clock, async active-low reset
//   fetch_en, pc, pc4        : fetch advance and current PC / PC+4
//   npc, pred_taken          : combinational prediction for pc
//   fetch_stall              : in-flight FIFO full
//   res_valid/is_br/pc/taken/target : resolve-stage retirement info
//   flush, redirect_pc       : registered 1-cycle squash and corrected PC
//   q_err                    : sticky pop-on-empty
//   hit_cnt, miss_cnt        : saturating prediction statistics
module branch_pred_ctrl
  import branch_pred_ctrl_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int QDEPTH = 4,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             fetch_en,
  input  logic [31:0]      pc,
  input  logic [31:0]      pc4,
  output logic [31:0]      npc,
  output logic             pred_taken,
  output logic             fetch_stall,
  input  logic             res_valid,
  input  logic             res_is_br,
  input  logic [31:0]      res_pc,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic             q_err,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;
  localparam int QCNT_W  = $clog2(QDEPTH) + 1;

  bpred_t            state_r  [ENTRIES];
  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [31:0]       target_r [ENTRIES];

  logic              flush_r;
  logic [31:0]       redirect_r;
  logic              q_err_r;
  logic [CNT_W-1:0]  hit_cnt_r;
  logic [CNT_W-1:0]  miss_cnt_r;

  logic [IDX_W-1:0]  f_idx_s;
  logic [TAG_W-1:0]  f_tag_s;
  logic              f_hit_s;
  logic [IDX_W-1:0]  r_idx_s;
  logic [TAG_W-1:0]  r_tag_s;

  bpq_entry_t        push_entry_s;
  bpq_entry_t        q_head_s;
  bpq_entry_t        res_entry_s;
  logic              q_full_s;
  logic              q_empty_s;
  logic [QCNT_W-1:0] q_count_s;
  logic              push_s;
  logic              pop_req_s;
  logic              resolve_s;
  logic              mispredict_s;
  logic              correct_s;

  // Lookup: reads registered table state, so a same-cycle training write
  // to the same index is not visible until the next cycle.
  assign f_idx_s    = pc[IDX_W+1:2];
  assign f_tag_s    = pc[31:IDX_W+2];
  assign f_hit_s    = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
  assign pred_taken = f_hit_s && bpred_is_taken(state_r[f_idx_s]);
  assign npc        = pred_taken ? target_r[f_idx_s] : pc4;

  assign r_idx_s = res_pc[IDX_W+1:2];
  assign r_tag_s = res_pc[31:IDX_W+2];

  assign fetch_stall = q_full_s;
  assign push_s      = fetch_en & ~q_full_s & ~flush_r;
  assign pop_req_s   = res_valid & ~flush_r;

  assign push_entry_s.pc   = pc;
  assign push_entry_s.pred = pred_taken;
  assign push_entry_s.npc  = npc;

  branch_pred_ctrl_queue #(.DEPTH(QDEPTH)) u_queue (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (push_s),
    .pop   (pop_req_s),
    .clear (flush_r),
    .wdata (push_entry_s),
    .head  (q_head_s),
    .full  (q_full_s),
    .empty (q_empty_s),
    .count (q_count_s)
  );

  // Resolve compare against the FIFO head; an empty FIFO stands in a
  // not-taken fall-through prediction so the branch still gets checked.
  always_comb begin
    res_entry_s  = q_head_s;
    resolve_s    = res_valid & res_is_br & ~flush_r;
    mispredict_s = 1'b0;
    correct_s    = 1'b0;
    if (q_empty_s) begin
      res_entry_s.pc   = res_pc;
      res_entry_s.pred = 1'b0;
      res_entry_s.npc  = res_pc + 32'd4;
    end else begin
      res_entry_s = q_head_s;
    end
    if (resolve_s) begin
      mispredict_s = (res_entry_s.pred != res_taken) ||
                     (res_taken && (res_entry_s.npc != res_target));
      correct_s    = ~mispredict_s;
    end else begin
      mispredict_s = 1'b0;
      correct_s    = 1'b0;
    end
  end

  // Predictor table training; tag/target only learned on taken outcomes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_r[i]  <= BPRED_NH;
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= 32'd0;
      end
    end else if (resolve_s) begin
      state_r[r_idx_s] <= bpred_next(state_r[r_idx_s], res_taken);
      if (res_taken) begin
        valid_r[r_idx_s]  <= 1'b1;
        tag_r[r_idx_s]    <= r_tag_s;
        target_r[r_idx_s] <= res_target;
      end
    end
  end

  // Flush/redirect, sticky queue error and saturating statistics.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      flush_r    <= 1'b0;
      redirect_r <= 32'd0;
      q_err_r    <= 1'b0;
      hit_cnt_r  <= {CNT_W{1'b0}};
      miss_cnt_r <= {CNT_W{1'b0}};
    end else begin
      flush_r <= mispredict_s;
      if (mispredict_s) begin
        redirect_r <= res_taken ? res_target : (res_pc + 32'd4);
      end
      if (pop_req_s && q_empty_s) begin
        q_err_r <= 1'b1;
      end
      if (correct_s && (hit_cnt_r != {CNT_W{1'b1}})) begin
        hit_cnt_r <= hit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (mispredict_s && (miss_cnt_r != {CNT_W{1'b1}})) begin
        miss_cnt_r <= miss_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign flush       = flush_r;
  assign redirect_pc = redirect_r;
  assign q_err       = q_err_r;
  assign hit_cnt     = hit_cnt_r;
  assign miss_cnt    = miss_cnt_r;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed self-checking bench for branch_pred_ctrl.
module tb_branch_pred_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        fetch_en;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] npc;
  logic        pred_taken;
  logic        fetch_stall;
  logic        res_valid;
  logic        res_is_br;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        q_err;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  branch_pred_ctrl #(.IDX_W(4), .QDEPTH(4), .CNT_W(16)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .fetch_en    (fetch_en),
    .pc          (pc),
    .pc4         (pc4),
    .npc         (npc),
    .pred_taken  (pred_taken),
    .fetch_stall (fetch_stall),
    .res_valid   (res_valid),
    .res_is_br   (res_is_br),
    .res_pc      (res_pc),
    .res_taken   (res_taken),
    .res_target  (res_target),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .q_err       (q_err),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Push the current pc, then resolve it as a branch on the following cycle.
  task automatic push_then_resolve(input logic [31:0] rpc, input logic tk, input logic [31:0] tgt);
    fetch_en = 1'b1;
    tick();
    fetch_en   = 1'b0;
    res_valid  = 1'b1;
    res_is_br  = 1'b1;
    res_pc     = rpc;
    res_taken  = tk;
    res_target = tgt;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; fetch_en = 1'b0; res_valid = 1'b0; res_is_br = 1'b0;
    res_pc = 32'd0; res_taken = 1'b0; res_target = 32'd0;
    pc = 32'h40; pc4 = 32'h44;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_npc", npc, 32'h44);
    chk("rst_pred", {31'd0, pred_taken}, 32'd0);
    chk("rst_stall", {31'd0, fetch_stall}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_qerr", {31'd0, q_err}, 32'd0);
    chk("rst_hit", {16'd0, hit_cnt}, 32'd0);
    chk("rst_miss", {16'd0, miss_cnt}, 32'd0);
    nRST = 1'b1;

    // NH, predicted not-taken, resolves taken to 0x100 -> mispredict, NS.
    push_then_resolve(32'h40, 1'b1, 32'h100);
    chk("m1_flush", {31'd0, flush}, 32'd1);
    chk("m1_redirect", redirect_pc, 32'h100);
    chk("m1_miss", {16'd0, miss_cnt}, 32'd1);
    chk("m1_hit", {16'd0, hit_cnt}, 32'd0);
    tick();
    chk("m1_flush_clr", {31'd0, flush}, 32'd0);
    chk("ns_npc", npc, 32'h44);
    chk("ns_pred", {31'd0, pred_taken}, 32'd0);

    // NS + taken -> TH, still mispredicted this time.
    push_then_resolve(32'h40, 1'b1, 32'h100);
    chk("m2_flush", {31'd0, flush}, 32'd1);
    chk("m2_miss", {16'd0, miss_cnt}, 32'd2);
    tick();
    chk("th_pred", {31'd0, pred_taken}, 32'd1);
    chk("th_npc", npc, 32'h100);

    // TH predicts 0x100 correctly.
    push_then_resolve(32'h40, 1'b1, 32'h100);
    chk("h1_flush", {31'd0, flush}, 32'd0);
    chk("h1_hit", {16'd0, hit_cnt}, 32'd1);
    chk("h1_miss", {16'd0, miss_cnt}, 32'd2);

    // TH + not-taken -> mispredict to fall-through, TS still predicts taken.
    push_then_resolve(32'h40, 1'b0, 32'h100);
    chk("m3_flush", {31'd0, flush}, 32'd1);
    chk("m3_redirect", redirect_pc, 32'h44);
    chk("m3_miss", {16'd0, miss_cnt}, 32'd3);
    tick();
    chk("ts_pred", {31'd0, pred_taken}, 32'd1);
    chk("ts_npc", npc, 32'h100);

    // TS + taken -> TH, correct.
    push_then_resolve(32'h40, 1'b1, 32'h100);
    chk("h2_flush", {31'd0, flush}, 32'd0);
    chk("h2_hit", {16'd0, hit_cnt}, 32'd2);

    // TH + not-taken -> TS; resolve inputs during the flush cycle are ignored.
    push_then_resolve(32'h40, 1'b0, 32'h100);
    chk("m4_miss", {16'd0, miss_cnt}, 32'd4);
    fetch_en = 1'b1; res_valid = 1'b1; res_is_br = 1'b1; res_taken = 1'b1; res_target = 32'h100;
    tick();
    fetch_en = 1'b0; res_valid = 1'b0;
    chk("fl_ign_flush", {31'd0, flush}, 32'd0);
    chk("fl_ign_qerr", {31'd0, q_err}, 32'd0);
    chk("fl_ign_miss", {16'd0, miss_cnt}, 32'd4);
    chk("fl_ign_hit", {16'd0, hit_cnt}, 32'd2);
    chk("ts2_pred", {31'd0, pred_taken}, 32'd1);

    // TS + not-taken -> NH.
    push_then_resolve(32'h40, 1'b0, 32'h100);
    chk("m5_miss", {16'd0, miss_cnt}, 32'd5);
    chk("m5_redirect", redirect_pc, 32'h44);
    tick();
    chk("nh_pred", {31'd0, pred_taken}, 32'd0);
    chk("nh_npc", npc, 32'h44);

    // Non-branch pop: no check, no stats.
    pc = 32'h80; pc4 = 32'h84;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; res_valid = 1'b1; res_is_br = 1'b0; res_pc = 32'h80;
    res_taken = 1'b1; res_target = 32'h300;
    tick();
    res_valid = 1'b0;
    chk("nb_flush", {31'd0, flush}, 32'd0);
    chk("nb_hit", {16'd0, hit_cnt}, 32'd2);
    chk("nb_miss", {16'd0, miss_cnt}, 32'd5);
    chk("nb_npc", npc, 32'h84);

    // Fill the FIFO, drop the 5th push, then push+pop balance.
    pc = 32'h200; pc4 = 32'h204;
    fetch_en = 1'b1;
    repeat (4) tick();
    chk("full_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    fetch_en = 1'b0;
    chk("full_hold", {31'd0, fetch_stall}, 32'd1);
    res_valid = 1'b1; res_is_br = 1'b0;
    tick();
    chk("pop3_stall", {31'd0, fetch_stall}, 32'd0);
    fetch_en = 1'b1;
    tick();
    chk("pushpop_stall", {31'd0, fetch_stall}, 32'd0);
    res_valid = 1'b0;
    tick();
    fetch_en = 1'b0;
    chk("refill_stall", {31'd0, fetch_stall}, 32'd1);
    res_valid = 1'b1;
    repeat (4) tick();
    chk("drain_qerr", {31'd0, q_err}, 32'd0);
    chk("drain_stall", {31'd0, fetch_stall}, 32'd0);
    tick();
    res_valid = 1'b0;
    chk("empty_qerr", {31'd0, q_err}, 32'd1);
    tick();
    chk("sticky_qerr", {31'd0, q_err}, 32'd1);

    // Asynchronous reset with a full FIFO.
    fetch_en = 1'b1;
    repeat (4) tick();
    fetch_en = 1'b0;
    chk("pre_rst_stall", {31'd0, fetch_stall}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("arst_stall", {31'd0, fetch_stall}, 32'd0);
    chk("arst_qerr", {31'd0, q_err}, 32'd0);
    chk("arst_miss", {16'd0, miss_cnt}, 32'd0);
    chk("arst_hit", {16'd0, hit_cnt}, 32'd0);
    tick();
    nRST = 1'b1;

    // Asynchronous reset during a flush cycle.
    pc = 32'h40; pc4 = 32'h44;
    push_then_resolve(32'h40, 1'b1, 32'h100);
    chk("mf_flush", {31'd0, flush}, 32'd1);
    chk("mf_miss", {16'd0, miss_cnt}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("mf_rst_flush", {31'd0, flush}, 32'd0);
    chk("mf_rst_redirect", redirect_pc, 32'd0);
    chk("mf_rst_miss", {16'd0, miss_cnt}, 32'd0);
    tick();
    nRST = 1'b1;
    tick();
    chk("mf_no_pending", {31'd0, flush}, 32'd0);
    chk("mf_npc", npc, 32'h44);
    res_valid = 1'b1; res_is_br = 1'b0;
    tick();
    res_valid = 1'b0;
    chk("mf_fifo_empty", {31'd0, q_err}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
